// File: rtl/inv_key_schedule_seq_pkg.sv
// Shared AES definitions: round count, FSM states,
// round constants and column-word helpers.
package inv_key_schedule_seq_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Column j of a row-major packed state
  function automatic logic [31:0] col_get(
    input logic [127:0] k,
    input int           j
  );
    return {k[127-8*j -: 8], k[95-8*j -: 8],
            k[63-8*j -: 8],  k[31-8*j -: 8]};
  endfunction

  function automatic logic [127:0] col_pack(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [31:0] d
  );
    return {a[31:24], b[31:24], c[31:24], d[31:24],
            a[23:16], b[23:16], c[23:16], d[23:16],
            a[15:8],  b[15:8],  c[15:8],  d[15:8],
            a[7:0],   b[7:0],   c[7:0],   d[7:0]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse as x^254
// followed by the affine transform.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128;
  logic [7:0] inv;

  // Inverse by repeated squaring, then affine map
  always_comb begin
    x2    = gmul(in_i, in_i);
    x4    = gmul(x2, x2);
    x8    = gmul(x4, x4);
    x16   = gmul(x8, x8);
    x32   = gmul(x16, x16);
    x64   = gmul(x32, x32);
    x128  = gmul(x64, x64);
    inv   = gmul(gmul(gmul(x2, x4), gmul(x8, x16)),
                 gmul(gmul(x32, x64), x128));
    out_o = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/inv_key_schedule_seq.sv
// Sequential AES-128 inverse key schedule: emits
// round keys 10 down to 0 over a valid/ready stream.
import inv_key_schedule_seq_pkg::*;

module inv_key_schedule_seq #(
  parameter int NR = AES_NR
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         key_is_last_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_round_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] i0, i1, i2, i3;
  logic [31:0] sub_in, sub_out;
  logic [7:0]  fwd_rc, inv_rc;

  // Round datapath; the S-box input is steered by state
  always_comb begin
    w0     = col_get(key_q, 0);
    w1     = col_get(key_q, 1);
    w2     = col_get(key_q, 2);
    w3     = col_get(key_q, 3);
    i3     = w3 ^ w2;
    i2     = w2 ^ w1;
    i1     = w1 ^ w0;
    sub_in = (state_q == EXPAND) ? rot_word(w3)
                                 : rot_word(i3);
    fwd_rc = rcon(4'(round_q + 4'd1));
    inv_rc = rcon(round_q);
    f0     = w0 ^ sub_out ^ {fwd_rc, 24'h0};
    f1     = w1 ^ f0;
    f2     = w2 ^ f1;
    f3     = w3 ^ f2;
    i0     = w0 ^ sub_out ^ {inv_rc, 24'h0};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sub_in[8*g +: 8]),
      .out_o (sub_out[8*g +: 8])
    );
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d = key_i;
          if (key_is_last_i) begin
            state_d = EMIT;
            round_d = 4'(NR);
          end else begin
            state_d = EXPAND;
            round_d = 4'd0;
          end
        end
      end
      EXPAND: begin
        key_d   = col_pack(f0, f1, f2, f3);
        round_d = 4'(round_q + 4'd1);
        if (round_q == 4'(NR - 1)) state_d = EMIT;
      end
      EMIT: begin
        if (rk_ready_i) begin
          if (round_q != 4'd0) begin
            key_d   = col_pack(i0, i1, i2, i3);
            round_d = 4'(round_q - 4'd1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == EMIT);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rk_o       = key_q;
  assign rk_round_o = round_q;
  assign rk_valid_o = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
